// File: rtl/sram_model_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_model_if
// Brief    : External 16-bit async SRAM bus (address, data, byte/chip strobes).
// Revision : 1.0 - initial release
// ============================================================================
interface sram_model_if #(
    parameter int ADDR_W = 18
);
    logic [ADDR_W-1:0] SRAM_ADDR;
    wire  [15:0]       SRAM_DQ;
    logic              SRAM_UB_N;
    logic              SRAM_LB_N;
    logic              SRAM_WE_N;
    logic              SRAM_CE_N;
    logic              SRAM_OE_N;
    // Per-lane drive enables of the memory side ({upper, lower}), mirrors the DQ tristate.
    logic [1:0]        dq_oe;

    modport master (
        output SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N,
        inout  SRAM_DQ,
        input  dq_oe
    );

    modport slave (
        input  SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N,
        inout  SRAM_DQ,
        output dq_oe
    );
endinterface
`default_nettype wire

// File: rtl/sram_model.sv
`default_nettype none
// ============================================================================
// Module   : sram_model
// Brief    : Cycle-accurate 16-bit SRAM chip model with read latency pipeline,
//            byte-lane writes, address-range flag and saturating access counters.
// Revision : 1.0 - initial release
// ============================================================================
module sram_model #(
    parameter int ADDR_W       = 18,
    parameter int DEPTH        = 4096,
    parameter int READ_LATENCY = 1
) (
    input  wire logic   clk,
    input  wire logic   rst,
    sram_model_if.slave bus,
    output logic        addr_err,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);
    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [15:0]        r_mem [DEPTH];
    logic               w_rd_cond;
    logic               w_wr_cond;
    logic               w_in_range;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_final_vld;
    logic [ADDR_W-1:0]  w_final_addr;
    logic               w_final_in_range;
    logic [15:0]        w_rd_data;
    logic               w_oe_lo;
    logic               w_oe_hi;
    logic               r_addr_err;
    logic [15:0]        r_rd_count;
    logic [15:0]        r_wr_count;

    assign w_rd_cond  = !bus.SRAM_CE_N && !bus.SRAM_OE_N && bus.SRAM_WE_N;
    assign w_wr_cond  = !bus.SRAM_CE_N && !bus.SRAM_WE_N;
    assign w_in_range = 64'(bus.SRAM_ADDR) < 64'(DEPTH);
    assign w_idx      = bus.SRAM_ADDR[c_IDX_W-1:0];

    // Array is deliberately outside the reset domain so contents survive rst.
    always_ff @(posedge clk) begin
        if (w_wr_cond && w_in_range) begin
            if (!bus.SRAM_LB_N) begin
                r_mem[w_idx][7:0] <= bus.SRAM_DQ[7:0];
            end
            if (!bus.SRAM_UB_N) begin
                r_mem[w_idx][15:8] <= bus.SRAM_DQ[15:8];
            end
        end
    end

    generate
        if (READ_LATENCY == 0) begin : g_lat0
            assign w_final_vld  = 1'b1;
            assign w_final_addr = bus.SRAM_ADDR;
        end else begin : g_pipe
            logic [READ_LATENCY-1:0] r_vld;
            logic [ADDR_W-1:0]       r_addr [READ_LATENCY];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_vld <= '0;
                    for (int k = 0; k < READ_LATENCY; k++) begin
                        r_addr[k] <= '0;
                    end
                end else begin
                    r_vld[0]  <= w_rd_cond;
                    r_addr[0] <= bus.SRAM_ADDR;
                    for (int k = 1; k < READ_LATENCY; k++) begin
                        r_vld[k]  <= r_vld[k-1];
                        r_addr[k] <= r_addr[k-1];
                    end
                end
            end

            assign w_final_vld  = r_vld[READ_LATENCY-1];
            assign w_final_addr = r_addr[READ_LATENCY-1];
        end
    endgenerate

    assign w_final_in_range = 64'(w_final_addr) < 64'(DEPTH);
    assign w_rd_data = w_final_in_range ? r_mem[w_final_addr[c_IDX_W-1:0]] : 16'h0000;

    // Gating with rst releases the bus immediately, even with zero latency.
    assign w_oe_lo = rst && w_rd_cond && !bus.SRAM_LB_N && w_final_vld;
    assign w_oe_hi = rst && w_rd_cond && !bus.SRAM_UB_N && w_final_vld;

    assign bus.SRAM_DQ = {w_oe_hi ? w_rd_data[15:8] : 8'hzz,
                          w_oe_lo ? w_rd_data[7:0]  : 8'hzz};
    assign bus.dq_oe   = {w_oe_hi, w_oe_lo};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr_err <= 1'b0;
            r_rd_count <= 16'h0000;
            r_wr_count <= 16'h0000;
        end else begin
            if (w_rd_cond && (r_rd_count != 16'hFFFF)) begin
                r_rd_count <= r_rd_count + 16'd1;
            end
            if (w_wr_cond && (r_wr_count != 16'hFFFF)) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
            if ((w_rd_cond || w_wr_cond) && !w_in_range) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    assign addr_err = r_addr_err;
    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
endmodule
`default_nettype wire
